// File: rtl/rf_scoreboard.sv
// rf_scoreboard: register-file hazard controller between decode and execute.
// Keeps a small pending-write counter per architectural register (x0 excluded)
// and a global inflight counter. The decode->exec issue handshake is blocked
// while a source has a pending write, the destination counter is saturated, or
// the inflight budget is exhausted.
// Optional build macro: SCOREBOARD_WB_BYPASS_EN -- a source whose only pending
// write retires or is cancelled this cycle is treated as ready in the same
// cycle (relies on a write-through register file read).
module rf_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4,
  localparam int AW          = $clog2(NUM_REGS),
  localparam int TW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid_i,
  output logic          issue_ready_o,
  input  logic          down_ready_i,
  input  logic [AW-1:0] issue_rs1_addr_i,
  input  logic [AW-1:0] issue_rs2_addr_i,
  input  logic          issue_rs1_use_i,
  input  logic          issue_rs2_use_i,
  input  logic [AW-1:0] issue_rd_addr_i,
  input  logic          issue_we_rd_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_rd_addr_i,
  input  logic          cancel_i,
  input  logic [AW-1:0] cancel_rd_addr_i,
  output logic          hazard_o,
  output logic          busy_o,
  output logic [TW-1:0] inflight_o,
  output logic          err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   CNT_ONE   = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [TW-1:0]    TOTAL_MAX = TW'(MAX_INFLIGHT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt [NUM_REGS];   // entry 0 is never written, stays 0
  logic [TW-1:0]    r_total;
  logic             r_err;
  logic             r_busy;

  // ---------------------------------------------------------------------------
  // Combinational decode of the current request
  // ---------------------------------------------------------------------------
  logic             w_wb_track;
  logic             w_cn_track;
  logic             w_rd_track;
  logic [CNT_W-1:0] w_rs1_cnt;
  logic [CNT_W-1:0] w_rs2_cnt;
  logic [CNT_W-1:0] w_rd_cnt;
  logic             w_rs1_pend;
  logic             w_rs2_pend;
  logic             w_src_pend;
  logic             w_sat;
  logic             w_full;
  logic             w_hazard;
  logic             w_ready;
  logic             w_fire_track;

  // Next-state values
  logic [CNT_W-1:0] w_cnt_nxt [NUM_REGS];
  logic [1:0]       w_dec_n;
  logic             w_uflow;
  logic [TW-1:0]    w_total_nxt;

`ifdef SCOREBOARD_WB_BYPASS_EN
  logic [CNT_W:0]   w_rs1_hits;
  logic [CNT_W:0]   w_rs2_hits;
`endif

  // Tracked retire/cancel/issue events (x0 is never tracked)
  always_comb begin
    w_wb_track = wb_we_i && (wb_rd_addr_i != '0);
    w_cn_track = cancel_i && (cancel_rd_addr_i != '0);
    w_rd_track = issue_we_rd_i && (issue_rd_addr_i != '0);
    w_rs1_cnt  = r_cnt[issue_rs1_addr_i];
    w_rs2_cnt  = r_cnt[issue_rs2_addr_i];
    w_rd_cnt   = r_cnt[issue_rd_addr_i];
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  // Same-cycle retire/cancel hits on each source; a source stays pending only
  // if more writes are outstanding than are leaving this cycle
  always_comb begin
    w_rs1_hits = (CNT_W+1)'(w_wb_track && (wb_rd_addr_i == issue_rs1_addr_i))
               + (CNT_W+1)'(w_cn_track && (cancel_rd_addr_i == issue_rs1_addr_i));
    w_rs2_hits = (CNT_W+1)'(w_wb_track && (wb_rd_addr_i == issue_rs2_addr_i))
               + (CNT_W+1)'(w_cn_track && (cancel_rd_addr_i == issue_rs2_addr_i));
    w_rs1_pend = issue_rs1_use_i && (issue_rs1_addr_i != '0)
               && ({1'b0, w_rs1_cnt} > w_rs1_hits);
    w_rs2_pend = issue_rs2_use_i && (issue_rs2_addr_i != '0)
               && ({1'b0, w_rs2_cnt} > w_rs2_hits);
  end
`else
  // Sources are pending while their raw counter is nonzero
  always_comb begin
    w_rs1_pend = issue_rs1_use_i && (issue_rs1_addr_i != '0) && (w_rs1_cnt != '0);
    w_rs2_pend = issue_rs2_use_i && (issue_rs2_addr_i != '0) && (w_rs2_cnt != '0);
  end
`endif

  // Hazard, saturation and inflight-budget gating of the issue handshake
  always_comb begin
    w_src_pend   = w_rs1_pend || w_rs2_pend;
    // Saturation always looks at the raw counter so it can never overflow
    w_sat        = w_rd_track && (w_rd_cnt == CNT_MAX);
    w_full       = issue_valid_i && w_rd_track && (r_total == TOTAL_MAX);
    w_hazard     = issue_valid_i && (w_src_pend || w_sat);
    w_ready      = down_ready_i && !w_hazard && !w_full;
    w_fire_track = issue_valid_i && w_ready && w_rd_track;
  end

  // Per-register net update: increment first, then retire, then cancel, each
  // decrement only taken if the count is still nonzero (else flag underflow)
  always_comb begin
    logic [CNT_W:0] v_cnt;
    v_cnt        = '0;
    w_dec_n      = 2'd0;
    w_uflow      = 1'b0;
    w_cnt_nxt[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      v_cnt = {1'b0, r_cnt[r]};
      if (w_fire_track && (issue_rd_addr_i == AW'(r))) begin
        v_cnt = v_cnt + CNT_ONE;
      end else begin
        v_cnt = v_cnt;
      end
      if (w_wb_track && (wb_rd_addr_i == AW'(r))) begin
        if (v_cnt != '0) begin
          v_cnt   = v_cnt - CNT_ONE;
          w_dec_n = w_dec_n + 2'd1;
        end else begin
          w_uflow = 1'b1;
        end
      end else begin
        v_cnt = v_cnt;
      end
      if (w_cn_track && (cancel_rd_addr_i == AW'(r))) begin
        if (v_cnt != '0) begin
          v_cnt   = v_cnt - CNT_ONE;
          w_dec_n = w_dec_n + 2'd1;
        end else begin
          w_uflow = 1'b1;
        end
      end else begin
        v_cnt = v_cnt;
      end
      w_cnt_nxt[r] = v_cnt[CNT_W-1:0];
    end
  end

  // Global inflight counter follows the same net delta as the per-register ones
  always_comb begin
    w_total_nxt = r_total + TW'(w_fire_track) - TW'(w_dec_n);
  end

  // Counter, inflight, busy and sticky-error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
      r_total <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
      r_total <= w_total_nxt;
      r_busy  <= (w_total_nxt != '0);
      r_err   <= r_err | w_uflow;
    end
  end

  // Output mapping
  always_comb begin
    issue_ready_o = w_ready;
    hazard_o      = w_hazard;
    busy_o        = r_busy;
    inflight_o    = r_total;
    err_o         = r_err;
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed testbench for rf_scoreboard. Expected values are hand-derived from
// the intended behaviour; the bypass build is selected with the same macro as
// the design (SCOREBOARD_WB_BYPASS_EN).
module tb_rf_scoreboard;

  logic       clk;
  logic       rst;
  logic       issue_valid_i;
  logic       issue_ready_o;
  logic       down_ready_i;
  logic [4:0] issue_rs1_addr_i;
  logic [4:0] issue_rs2_addr_i;
  logic       issue_rs1_use_i;
  logic       issue_rs2_use_i;
  logic [4:0] issue_rd_addr_i;
  logic       issue_we_rd_i;
  logic       wb_we_i;
  logic [4:0] wb_rd_addr_i;
  logic       cancel_i;
  logic [4:0] cancel_rd_addr_i;
  logic       hazard_o;
  logic       busy_o;
  logic [2:0] inflight_o;
  logic       err_o;

  int n_cmp;
  int n_bad;

  rf_scoreboard dut (
    .clk              (clk),
    .rst              (rst),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .down_ready_i     (down_ready_i),
    .issue_rs1_addr_i (issue_rs1_addr_i),
    .issue_rs2_addr_i (issue_rs2_addr_i),
    .issue_rs1_use_i  (issue_rs1_use_i),
    .issue_rs2_use_i  (issue_rs2_use_i),
    .issue_rd_addr_i  (issue_rd_addr_i),
    .issue_we_rd_i    (issue_we_rd_i),
    .wb_we_i          (wb_we_i),
    .wb_rd_addr_i     (wb_rd_addr_i),
    .cancel_i         (cancel_i),
    .cancel_rd_addr_i (cancel_rd_addr_i),
    .hazard_o         (hazard_o),
    .busy_o           (busy_o),
    .inflight_o       (inflight_o),
    .err_o            (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i    = 1'b0;
    issue_rs1_addr_i = 5'd0;
    issue_rs2_addr_i = 5'd0;
    issue_rs1_use_i  = 1'b0;
    issue_rs2_use_i  = 1'b0;
    issue_rd_addr_i  = 5'd0;
    issue_we_rd_i    = 1'b0;
    wb_we_i          = 1'b0;
    wb_rd_addr_i     = 5'd0;
    cancel_i         = 1'b0;
    cancel_rd_addr_i = 5'd0;
  endtask

  task automatic issue_write(input logic [4:0] rd);
    issue_valid_i   = 1'b1;
    issue_we_rd_i   = 1'b1;
    issue_rd_addr_i = rd;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    down_ready_i = 1'b1;
    rst = 1'b1;
    #1;
    // Reset state
    check_val("rst_inflight", 32'(inflight_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_err", 32'(err_o), 32'd0);
    check_val("rst_hazard", 32'(hazard_o), 32'd0);
    check_val("rst_ready_dr1", 32'(issue_ready_o), 32'd1);
    down_ready_i = 1'b0;
    #1;
    check_val("rst_ready_dr0", 32'(issue_ready_o), 32'd0);
    down_ready_i = 1'b1;
    step();
    rst = 1'b0;
    step();

    // ADD x5 (reads x1, idle) -> fires
    issue_write(5'd5);
    issue_rs1_use_i  = 1'b1;
    issue_rs1_addr_i = 5'd1;
    #1;
    check_val("add_ready", 32'(issue_ready_o), 32'd1);
    step();
    idle_inputs();
    #1;
    check_val("add_inflight", 32'(inflight_o), 32'd1);
    check_val("add_busy", 32'(busy_o), 32'd1);

    // Consumer of x5 while x5 retires
    issue_valid_i    = 1'b1;
    issue_rs1_use_i  = 1'b1;
    issue_rs1_addr_i = 5'd5;
    wb_we_i          = 1'b1;
    wb_rd_addr_i     = 5'd5;
    #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    check_val("raw_hazard_bp", 32'(hazard_o), 32'd0);
    check_val("raw_ready_bp", 32'(issue_ready_o), 32'd1);
    step();
    idle_inputs();
    #1;
`else
    check_val("raw_hazard", 32'(hazard_o), 32'd1);
    check_val("raw_ready", 32'(issue_ready_o), 32'd0);
    step();
    wb_we_i = 1'b0;
    #1;
    check_val("raw_hazard_next", 32'(hazard_o), 32'd0);
    check_val("raw_ready_next", 32'(issue_ready_o), 32'd1);
    step();
    idle_inputs();
    #1;
`endif
    check_val("raw_inflight", 32'(inflight_o), 32'd0);
    check_val("raw_busy", 32'(busy_o), 32'd0);

    // Saturation on x7
    issue_write(5'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("sat_fill_ready", 32'(issue_ready_o), 32'd1);
      step();
    end
    check_val("sat_inflight3", 32'(inflight_o), 32'd3);
    check_val("sat_hazard", 32'(hazard_o), 32'd1);
    check_val("sat_ready", 32'(issue_ready_o), 32'd0);
    wb_we_i      = 1'b1;
    wb_rd_addr_i = 5'd7;
    #1;
    check_val("sat_hazard_raw_cnt", 32'(hazard_o), 32'd1);
    step();
    wb_we_i = 1'b0;
    #1;
    check_val("sat_after_retire_inflight", 32'(inflight_o), 32'd2);
    check_val("sat_after_retire_ready", 32'(issue_ready_o), 32'd1);
    step();
    idle_inputs();
    #1;
    check_val("sat_4th_inflight", 32'(inflight_o), 32'd3);
    wb_we_i      = 1'b1;
    wb_rd_addr_i = 5'd7;
    for (int i = 0; i < 3; i++) step();
    idle_inputs();
    #1;
    check_val("sat_drain_inflight", 32'(inflight_o), 32'd0);

    // Inflight budget
    for (int r = 1; r <= 4; r++) begin
      issue_write(5'(r));
      step();
    end
    check_val("full_inflight4", 32'(inflight_o), 32'd4);
    issue_we_rd_i = 1'b0;
    issue_rd_addr_i = 5'd6;
    #1;
    check_val("full_nowrite_ready", 32'(issue_ready_o), 32'd1);
    issue_we_rd_i = 1'b1;
    wb_we_i       = 1'b1;
    wb_rd_addr_i  = 5'd1;
    #1;
    check_val("full_ready", 32'(issue_ready_o), 32'd0);
    check_val("full_hazard", 32'(hazard_o), 32'd0);
    step();
    wb_we_i = 1'b0;
    #1;
    check_val("full_after_retire_inflight", 32'(inflight_o), 32'd3);
    check_val("full_after_retire_ready", 32'(issue_ready_o), 32'd1);
    step();
    idle_inputs();
    #1;
    check_val("full_5th_inflight", 32'(inflight_o), 32'd4);
    wb_we_i = 1'b1;
    wb_rd_addr_i = 5'd2; step();
    wb_rd_addr_i = 5'd3; step();
    wb_rd_addr_i = 5'd4; step();
    wb_rd_addr_i = 5'd6; step();
    idle_inputs();
    #1;
    check_val("full_drain_inflight", 32'(inflight_o), 32'd0);

    // Fire and retire on the same rd in one cycle
    issue_write(5'd8);
    step();
    wb_we_i      = 1'b1;
    wb_rd_addr_i = 5'd8;
    #1;
    check_val("same_ready", 32'(issue_ready_o), 32'd1);
    step();
    idle_inputs();
    #1;
    check_val("same_inflight", 32'(inflight_o), 32'd1);
    issue_valid_i    = 1'b1;
    issue_rs2_use_i  = 1'b1;
    issue_rs2_addr_i = 5'd8;
    #1;
    check_val("same_rs2_hazard", 32'(hazard_o), 32'd1);
    idle_inputs();
    wb_we_i      = 1'b1;
    wb_rd_addr_i = 5'd8;
    step();
    idle_inputs();
    #1;
    check_val("same_drain_inflight", 32'(inflight_o), 32'd0);

    // x0 is never tracked, never hazards
    issue_write(5'd0);
    issue_rs1_use_i = 1'b1;
    issue_rs2_use_i = 1'b1;
    wb_we_i         = 1'b1;
    wb_rd_addr_i    = 5'd0;
    #1;
    check_val("x0_hazard", 32'(hazard_o), 32'd0);
    check_val("x0_ready", 32'(issue_ready_o), 32'd1);
    step();
    idle_inputs();
    #1;
    check_val("x0_inflight", 32'(inflight_o), 32'd0);
    check_val("x0_err", 32'(err_o), 32'd0);

    // Cancel removes a pending write
    issue_write(5'd10);
    step();
    idle_inputs();
    cancel_i         = 1'b1;
    cancel_rd_addr_i = 5'd10;
    step();
    idle_inputs();
    #1;
    check_val("cancel_inflight", 32'(inflight_o), 32'd0);
    check_val("cancel_err", 32'(err_o), 32'd0);

    // Underflow and reset mid-stream
    issue_write(5'd3);
    step();
    step();
    idle_inputs();
    wb_we_i      = 1'b1;
    wb_rd_addr_i = 5'd9;
    step();
    idle_inputs();
    #1;
    check_val("uflow_err", 32'(err_o), 32'd1);
    check_val("uflow_inflight", 32'(inflight_o), 32'd2);
    step();
    step();
    check_val("uflow_err_sticky", 32'(err_o), 32'd1);
    issue_valid_i    = 1'b1;
    issue_rs1_use_i  = 1'b1;
    issue_rs1_addr_i = 5'd3;
    down_ready_i     = 1'b0;
    #1;
    check_val("uflow_x3_hazard", 32'(hazard_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_inflight", 32'(inflight_o), 32'd0);
    check_val("midrst_err", 32'(err_o), 32'd0);
    check_val("midrst_busy", 32'(busy_o), 32'd0);
    check_val("midrst_x3_hazard", 32'(hazard_o), 32'd0);
    down_ready_i = 1'b1;
    step();
    rst = 1'b0;
    step();
    #1;
    check_val("postrst_ready", 32'(issue_ready_o), 32'd1);
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Register-file hazard controller sitting between decode and execute.
- Tracks outstanding register writes per architectural register.
- Gates the decode→exec issue handshake so an instruction cannot issue while a source or destination register has a pending write it depends on.
- Retire and cancel inputs come from the MEM/WB stage and the flush logic.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; max pending writes per register = 2^CNT_W-1.
- MAX_INFLIGHT, 4, maximum total outstanding tracked writes across all registers.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- issue_valid_i  in  1  decode has an instruction to issue
- issue_ready_o  out  1  issue allowed this cycle
- down_ready_i  in  1  execute stage can accept
- issue_rs1_addr_i  in  5  source 1 address
- issue_rs2_addr_i  in  5  source 2 address
- issue_rs1_use_i  in  1  rs1 is actually read
- issue_rs2_use_i  in  1  rs2 is actually read
- issue_rd_addr_i  in  5  destination address
- issue_we_rd_i  in  1  instruction writes rd
- wb_we_i  in  1  writeback retires a write this cycle
- wb_rd_addr_i  in  5  retired destination
- cancel_i  in  1  an issued write was squashed and will never retire
- cancel_rd_addr_i  in  5  squashed destination
- hazard_o  out  1  issue blocked by a register dependency
- busy_o  out  1  any write outstanding
- inflight_o  out  $clog2(MAX_INFLIGHT+1)  total outstanding writes
- err_o  out  1  sticky protocol error

Behaviour:
- State:
  - cnt[r], a CNT_W counter for r = 1..NUM_REGS-1.
  - total, the inflight counter.
  - err_ff, the sticky error flag.
- Reset (async): all cnt=0, total=0, err_o=0; busy_o=0, hazard_o=0, inflight_o=0.
- Combinational outputs:
  - issue_ready_o = down_ready_i & ~hazard_o & ~full.
  - At reset issue_ready_o follows down_ready_i.
- Dependency rules (a register r counts as pending when its effective count is nonzero):
  - src_pend = (rs1_use & rs1!=0 & pend(rs1)) | (rs2_use & rs2!=0 & pend(rs2)).
  - sat = issue_we_rd & rd!=0 & cnt[rd]==2^CNT_W-1.
  - hazard_o = issue_valid_i & (src_pend | sat).
  - full = issue_valid_i & issue_we_rd_i & rd!=0 & total==MAX_INFLIGHT.
- Issue fire = issue_valid_i & issue_ready_o. On fire with we_rd & rd!=0: cnt[rd]+1, total+1.
- Writes to x0 never tracked. Reads of x0 never hazard.
- Retire (wb_we_i & wb_rd_addr!=0): cnt[wb_rd]-1, total-1.
- Cancel (cancel_i & cancel_rd!=0): cnt[cancel_rd]-1, total-1.
- Simultaneous events on the same register:
  - Net delta = +fire −retire −cancel, applied in one cycle.
  - Example: fire and retire on the same rd leaves cnt unchanged.
  - total uses the same net delta.
- Underflow:
  - Retire or cancel of a register whose count (after the same-cycle increment) is 0: counter held at 0, total not decremented, err_o set.
  - err_o clears only on reset.
- Overflow is impossible by construction: sat and full both stall issue.
- busy_o = (total != 0), registered value.
- inflight_o = total.
- Issue latency is zero cycles: hazard evaluation is combinational on the current counters.
- A hazard clears on the first cycle after the last pending write retires, or in the same cycle with the optional feature below.
- issue_ready_o may drop while issue_valid_i is held. Decode must keep its payload stable until fire.
- No internal FSM beyond the counters. Reset mid-operation discards all pending state.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- When defined:
  - pend(r) = (cnt[r] − retire_hit(r) − cancel_hit(r)) != 0.
  - A source whose only pending write retires this cycle is treated as ready and may issue in the same cycle. This relies on the register file's write-through read.
- When undefined:
  - pend(r) = cnt[r] != 0.
  - The dependent instruction issues one cycle after the retire.
- The sat check always uses the raw cnt in both builds.

Test Plan:
- Reset, then issue ADD x5 (we_rd) with down_ready=1 -> fire. Next cycle cnt[5]=1, busy_o=1, inflight_o=1.
- Next: issue using rs1=x5 -> hazard_o=1, issue_ready_o=0. wb_we=1, rd=5 that cycle:
  - with bypass: issue_ready_o=1 in the same cycle.
  - without bypass: issue_ready_o=1 the following cycle. cnt[5] ends at 0.
- Issue 3 writes to x7 with no retire -> cnt[7]=3. A 4th write to x7 -> hazard_o=1 (sat). One retire x7 -> the 4th issues next cycle, cnt[7]=3.
- Issue writes to x1,x2,x3,x4 (total=4). A 5th write to x6 -> issue_ready_o=0, hazard_o=0 (full). Retire x1 -> the 5th issues next cycle.
- Issue rd=x0 and a read of x0 -> no counter change, no hazard, inflight_o stays 0.
- Retire x9 with cnt[9]=0 -> err_o=1 and stays set, total unchanged. Assert rst mid-stream with cnt[3]=2 -> all counters 0, err_o=0 immediately.
